// File: rtl/regb_fifo_serializer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regb_fifo_serializer_pkg : shared FSM encodings for the FIFO serializer     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package regb_fifo_serializer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_DATA = 2'd1;
    localparam state_t ST_PAR  = 2'd2;

endpackage : regb_fifo_serializer_pkg
`default_nettype wire

// File: rtl/regb_fifo_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regb_fifo_serializer : pops words from the register FIFO output stage and   |
// | streams them bit-serially (optional even parity) over valid/ready.          |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module regb_fifo_serializer
    import regb_fifo_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit PARITY_EN = 1'b0
)(
    input  logic             clk,
    input  logic             res_n,
    input  logic [WIDTH-1:0] fifo_data,
    input  logic             fifo_empty_n,
    output logic             fifo_shift_out,
    output logic             ser_data,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             busy
);

    localparam int              CW         = $clog2(WIDTH);
    localparam logic [CW-1:0]   c_CNT_LOAD = CW'(WIDTH - 1);
    localparam logic [CW-1:0]   c_CNT_ONE  = CW'(1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_shreg;
    logic [CW-1:0]      r_bit_cnt;
    logic               r_par;

    logic               w_idle;
    logic               w_data_st;
    logic               w_par_st;
    logic               w_cnt_zero;
    logic               w_out_bit;
    logic [WIDTH-1:0]   w_shifted;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_data_st  = (r_state == ST_DATA);
    assign w_par_st   = (r_state == ST_PAR);
    assign w_cnt_zero = (r_bit_cnt == '0);

    // The output end of the shift register depends on bit order; vacated bits fill with 0.
    assign w_out_bit = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
    assign w_shifted = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0} : {1'b0, r_shreg[WIDTH-1:1]};

    // Popping on the final transfer of a word lets the next word follow without a bubble.
    assign fifo_shift_out = fifo_empty_n &
                            (w_idle |
                             (w_data_st & ser_ready & w_cnt_zero & !PARITY_EN) |
                             (w_par_st & ser_ready));

    assign ser_valid = w_data_st | w_par_st;
    assign ser_data  = (w_data_st & w_out_bit) | (w_par_st & r_par);
    assign ser_last  = (w_data_st & w_cnt_zero & !PARITY_EN) | w_par_st;
    assign busy      = !w_idle;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_state   <= ST_IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_par     <= 1'b0;
        end else if (fifo_shift_out) begin
            r_state   <= ST_DATA;
            r_shreg   <= fifo_data;
            r_bit_cnt <= c_CNT_LOAD;
            r_par     <= ^fifo_data;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_IDLE;
                end
                ST_DATA: begin
                    if (ser_ready) begin
                        if (!w_cnt_zero) begin
                            r_shreg   <= w_shifted;
                            r_bit_cnt <= r_bit_cnt - c_CNT_ONE;
                        end else if (PARITY_EN) begin
                            r_state <= ST_PAR;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_PAR: begin
                    if (ser_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : regb_fifo_serializer
`default_nettype wire
